// File: rtl/cmp_rs_if.sv
// Dispatch, CDB and issue-ack signals between a reservation station and its
// comparator. Also carries the per-entry view of the station toward the comparator.
interface cmp_rs_if #(
   parameter int SIZE  = 8,
   parameter int TAG_W = 4
);
   localparam int CW = $clog2(SIZE) + 1;

   typedef struct packed {
      logic [2:0]       op;
      logic [31:0]      r1;
      logic [31:0]      r2;
      logic [TAG_W-1:0] tag;
   } rs_t;

   // Handshake: a load is taken at the rising edge only when full is low.
   // A load presented while full is high is dropped. There is no other back-pressure.
   logic                 load;
   logic [2:0]           ld_op;
   logic [TAG_W-1:0]     ld_tag;
   logic [31:0]          ld_r1;
   logic [31:0]          ld_r2;
   logic                 ld_r1_rdy;
   logic                 ld_r2_rdy;
   logic [TAG_W-1:0]     ld_r1_tag;
   logic [TAG_W-1:0]     ld_r2_tag;
   logic                 cdb_vld;
   logic [TAG_W-1:0]     cdb_tag;
   logic [31:0]          cdb_data;
   logic [SIZE-1:0]      issue_ack;
   logic                 flush;
   rs_t  [SIZE-1:0]      data;
   logic [SIZE-1:0]      ready;
   logic                 full;
   logic [CW-1:0]        count;

   modport master (
      output load, ld_op, ld_tag, ld_r1, ld_r2, ld_r1_rdy, ld_r2_rdy,
             ld_r1_tag, ld_r2_tag, cdb_vld, cdb_tag, cdb_data, issue_ack, flush,
      input  data, ready, full, count
   );

   modport slave (
      input  load, ld_op, ld_tag, ld_r1, ld_r2, ld_r1_rdy, ld_r2_rdy,
             ld_r1_tag, ld_r2_tag, cdb_vld, cdb_tag, cdb_data, issue_ack, flush,
      output data, ready, full, count
   );
endinterface

// File: rtl/cmp_rs.sv
// Branch reservation station. Entries wait for operands, snoop the CDB,
// and present ready entries to the comparator until issue_ack frees them.
module cmp_rs #(
   parameter int SIZE  = 8,
   parameter int TAG_W = 4
) (
   input  logic     clk,
   input  logic     rst,
   cmp_rs_if.slave  bus
);
   localparam int CW = $clog2(SIZE) + 1;

   logic [SIZE-1:0]             valid_q;
   logic [SIZE-1:0]             r1_rdy_q;
   logic [SIZE-1:0]             r2_rdy_q;
   logic [SIZE-1:0][2:0]        op_q;
   logic [SIZE-1:0][TAG_W-1:0]  tag_q;
   logic [SIZE-1:0][TAG_W-1:0]  r1_tag_q;
   logic [SIZE-1:0][TAG_W-1:0]  r2_tag_q;
   logic [SIZE-1:0][31:0]       r1_q;
   logic [SIZE-1:0][31:0]       r2_q;

   logic [SIZE-1:0] alloc_oh;
   logic [SIZE-1:0] ready_w;
   logic            found;
   logic            load_ok;
   logic            byp1;
   logic            byp2;
   logic [CW-1:0]   cnt;

   // Lowest-index free slot, chosen from registered valid bits only.
   always_comb begin
      alloc_oh = '0;
      found    = 1'b0;
      for (int i = 0; i < SIZE; i++) begin
         if (!valid_q[i] && !found) begin
            alloc_oh[i] = 1'b1;
            found       = 1'b1;
         end
      end
   end

   always_comb begin
      cnt = '0;
      for (int i = 0; i < SIZE; i++) cnt = cnt + CW'(valid_q[i]);
   end

   assign ready_w = valid_q & r1_rdy_q & r2_rdy_q;
   assign load_ok = bus.load & ~(&valid_q);
   assign byp1    = bus.cdb_vld & ~bus.ld_r1_rdy & (bus.cdb_tag == bus.ld_r1_tag);
   assign byp2    = bus.cdb_vld & ~bus.ld_r2_rdy & (bus.cdb_tag == bus.ld_r2_tag);

   assign bus.ready = ready_w;
   assign bus.full  = &valid_q;
   assign bus.count = cnt;

   always_comb begin
      bus.data = '0;
      for (int i = 0; i < SIZE; i++) begin
         bus.data[i].op  = op_q[i];
         bus.data[i].r1  = r1_q[i];
         bus.data[i].r2  = r2_q[i];
         bus.data[i].tag = valid_q[i] ? tag_q[i] : '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q  <= '0;
         r1_rdy_q <= '0;
         r2_rdy_q <= '0;
         op_q     <= '0;
         tag_q    <= '0;
         r1_tag_q <= '0;
         r2_tag_q <= '0;
         r1_q     <= '0;
         r2_q     <= '0;
      end else if (bus.flush) begin
         valid_q <= '0;
      end else begin
         for (int i = 0; i < SIZE; i++) begin
            if (load_ok && alloc_oh[i]) begin
               valid_q[i]  <= 1'b1;
               op_q[i]     <= bus.ld_op;
               tag_q[i]    <= bus.ld_tag;
               r1_q[i]     <= byp1 ? bus.cdb_data : bus.ld_r1;
               r2_q[i]     <= byp2 ? bus.cdb_data : bus.ld_r2;
               r1_rdy_q[i] <= bus.ld_r1_rdy | byp1;
               r2_rdy_q[i] <= bus.ld_r2_rdy | byp2;
               r1_tag_q[i] <= bus.ld_r1_tag;
               r2_tag_q[i] <= bus.ld_r2_tag;
            end else if (valid_q[i]) begin
               // An acknowledged entry is freed outright; it never snoops on its way out.
               if (bus.issue_ack[i] && ready_w[i]) begin
                  valid_q[i] <= 1'b0;
               end else begin
                  if (bus.cdb_vld && !r1_rdy_q[i] && (r1_tag_q[i] == bus.cdb_tag)) begin
                     r1_q[i]     <= bus.cdb_data;
                     r1_rdy_q[i] <= 1'b1;
                  end
                  if (bus.cdb_vld && !r2_rdy_q[i] && (r2_tag_q[i] == bus.cdb_tag)) begin
                     r2_q[i]     <= bus.cdb_data;
                     r2_rdy_q[i] <= 1'b1;
                  end
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_cmp_rs.sv
// Directed bench for cmp_rs: entry-level model checked every cycle,
// plus literal expectations for the key dispatch/snoop/full/flush/reset cases.
module tb_cmp_rs;
   localparam int SIZE  = 8;
   localparam int TAG_W = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;

   cmp_rs_if #(.SIZE(SIZE), .TAG_W(TAG_W)) bus();
   cmp_rs #(.SIZE(SIZE), .TAG_W(TAG_W)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   // Model: one record per entry, updated by the rules each rising edge.
   bit               m_valid [SIZE];
   bit               m_r1r   [SIZE];
   bit               m_r2r   [SIZE];
   logic [2:0]       m_op    [SIZE];
   logic [TAG_W-1:0] m_tag   [SIZE];
   logic [TAG_W-1:0] m_t1    [SIZE];
   logic [TAG_W-1:0] m_t2    [SIZE];
   logic [31:0]      m_r1    [SIZE];
   logic [31:0]      m_r2    [SIZE];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < SIZE; i++) begin
            m_valid[i] = 0; m_r1r[i] = 0; m_r2r[i] = 0;
            m_op[i] = '0; m_tag[i] = '0; m_t1[i] = '0; m_t2[i] = '0;
            m_r1[i] = '0; m_r2[i] = '0;
         end
      end else if (bus.flush) begin
         for (int i = 0; i < SIZE; i++) m_valid[i] = 0;
      end else begin
         bit was_full;
         int slot;
         bit rdy_now [SIZE];
         was_full = 1;
         slot     = -1;
         for (int i = 0; i < SIZE; i++) begin
            rdy_now[i] = m_valid[i] && m_r1r[i] && m_r2r[i];
            if (!m_valid[i]) begin
               was_full = 0;
               if (slot < 0) slot = i;
            end
         end
         for (int i = 0; i < SIZE; i++) begin
            if (m_valid[i]) begin
               if (bus.issue_ack[i] && rdy_now[i]) m_valid[i] = 0;
               else if (bus.cdb_vld) begin
                  if (!m_r1r[i] && m_t1[i] == bus.cdb_tag) begin m_r1[i] = bus.cdb_data; m_r1r[i] = 1; end
                  if (!m_r2r[i] && m_t2[i] == bus.cdb_tag) begin m_r2[i] = bus.cdb_data; m_r2r[i] = 1; end
               end
            end
         end
         if (bus.load && !was_full) begin
            m_valid[slot] = 1;
            m_op[slot]    = bus.ld_op;
            m_tag[slot]   = bus.ld_tag;
            m_t1[slot]    = bus.ld_r1_tag;
            m_t2[slot]    = bus.ld_r2_tag;
            m_r1r[slot]   = bus.ld_r1_rdy || (bus.cdb_vld && bus.cdb_tag == bus.ld_r1_tag);
            m_r2r[slot]   = bus.ld_r2_rdy || (bus.cdb_vld && bus.cdb_tag == bus.ld_r2_tag);
            m_r1[slot]    = bus.ld_r1_rdy ? bus.ld_r1 : bus.cdb_data;
            m_r2[slot]    = bus.ld_r2_rdy ? bus.ld_r2 : bus.cdb_data;
         end
      end
   end

   // Compare on the falling edge, away from the active edge.
   always @(negedge clk) begin
      logic [SIZE-1:0] er;
      int cnt;
      cnt = 0;
      for (int i = 0; i < SIZE; i++) begin
         er[i] = m_valid[i] && m_r1r[i] && m_r2r[i];
         cnt  += int'(m_valid[i]);
      end
      check("ready", bus.ready, er);
      check("count", bus.count, cnt);
      check("full", bus.full, cnt == SIZE);
      for (int i = 0; i < SIZE; i++) begin
         check($sformatf("data[%0d].op", i), bus.data[i].op, m_op[i]);
         check($sformatf("data[%0d].tag", i), bus.data[i].tag, m_valid[i] ? m_tag[i] : '0);
         if (m_r1r[i]) check($sformatf("data[%0d].r1", i), bus.data[i].r1, m_r1[i]);
         if (m_r2r[i]) check($sformatf("data[%0d].r2", i), bus.data[i].r2, m_r2[i]);
      end
   end

   task automatic idle();
      bus.load = 0; bus.ld_op = '0; bus.ld_tag = '0;
      bus.ld_r1 = '0; bus.ld_r2 = '0; bus.ld_r1_rdy = 0; bus.ld_r2_rdy = 0;
      bus.ld_r1_tag = '0; bus.ld_r2_tag = '0;
      bus.cdb_vld = 0; bus.cdb_tag = '0; bus.cdb_data = '0;
      bus.issue_ack = '0; bus.flush = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_load(input logic [2:0] op, input logic [TAG_W-1:0] tag,
                           input logic [31:0] r1, input logic r1r, input logic [TAG_W-1:0] t1,
                           input logic [31:0] r2, input logic r2r, input logic [TAG_W-1:0] t2);
      bus.load = 1; bus.ld_op = op; bus.ld_tag = tag;
      bus.ld_r1 = r1; bus.ld_r1_rdy = r1r; bus.ld_r1_tag = t1;
      bus.ld_r2 = r2; bus.ld_r2_rdy = r2r; bus.ld_r2_tag = t2;
   endtask

   task automatic set_cdb(input logic [TAG_W-1:0] tag, input logic [31:0] d);
      bus.cdb_vld = 1; bus.cdb_tag = tag; bus.cdb_data = d;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      idle();
      rst = 0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_count", bus.count, 0);
      check("rst_ready", bus.ready, 0);
      rst = 1;
      tick();

      // beq, both operands ready
      set_load(3'd0, 4'd3, 32'd5, 1, 4'd0, 32'd5, 1, 4'd0);
      tick(); idle();
      check("beq_ready", bus.ready, 8'b0000_0001);
      check("beq_tag", bus.data[0].tag, 3);
      check("beq_count", bus.count, 1);
      bus.issue_ack = 8'h01;
      tick(); idle();
      check("ack_count", bus.count, 0);

      // r1 pending on tag 7, completed by CDB two cycles later
      set_load(3'd0, 4'd2, 32'd0, 0, 4'd7, 32'd9, 1, 4'd0);
      tick(); idle();
      check("snoop_wait_ready", bus.ready, 8'h00);
      tick();
      set_cdb(4'd7, 32'd9);
      tick(); idle();
      check("snoop_ready", bus.ready, 8'h01);
      check("snoop_r1", bus.data[0].r1, 9);
      bus.issue_ack = 8'h01;
      tick(); idle();

      // dispatch bypass on r2
      set_load(3'd1, 4'd4, 32'd1, 1, 4'd0, 32'd0, 0, 4'd5);
      set_cdb(4'd5, 32'hFFFF_FFFF);
      tick(); idle();
      check("bypass_ready", bus.ready, 8'h01);
      check("bypass_r2", bus.data[0].r2, 32'hFFFF_FFFF);
      bus.issue_ack = 8'h01;
      tick(); idle();

      // fill, overfill, ack+load while full, refill
      for (int i = 0; i < SIZE; i++) begin
         set_load(3'd2, 4'(i), 32'(i * 3), 1, 4'd0, 32'(i + 100), 1, 4'd0);
         tick();
      end
      idle();
      check("fill_full", bus.full, 1);
      check("fill_count", bus.count, 8);
      set_load(3'd3, 4'd15, 32'd1, 1, 4'd0, 32'd2, 1, 4'd0);
      tick(); idle();
      check("over_count", bus.count, 8);
      check("over_tag7", bus.data[7].tag, 7);
      set_load(3'd3, 4'd14, 32'd1, 1, 4'd0, 32'd2, 1, 4'd0);
      bus.issue_ack = 8'h10;
      tick(); idle();
      check("ackfull_count", bus.count, 7);
      check("ackfull_ready", bus.ready, 8'hEF);
      check("ackfull_tag4", bus.data[4].tag, 0);
      set_load(3'd5, 4'd13, 32'd1, 1, 4'd0, 32'd2, 1, 4'd0);
      tick(); idle();
      check("refill_tag4", bus.data[4].tag, 13);
      check("refill_count", bus.count, 8);
      bus.flush = 1;
      tick(); idle();

      // flush beats load and snoop
      for (int i = 0; i < 4; i++) begin
         set_load(3'd4, 4'(i + 8), 32'd0, (i % 2) == 0, 4'd6, 32'(i), 1, 4'd0);
         tick();
      end
      idle();
      check("pre_flush_count", bus.count, 4);
      bus.flush = 1;
      set_load(3'd0, 4'd1, 32'd1, 1, 4'd0, 32'd1, 1, 4'd0);
      set_cdb(4'd6, 32'h1234);
      tick(); idle();
      check("flush_ready", bus.ready, 0);
      check("flush_count", bus.count, 0);
      check("flush_full", bus.full, 0);
      tick();
      check("flush_hold_count", bus.count, 0);

      // asynchronous reset mid-cycle
      for (int i = 0; i < 3; i++) begin
         set_load(3'd1, 4'(i + 1), 32'(i + 40), 1, 4'd0, 32'(i + 50), 1, 4'd0);
         tick();
      end
      idle();
      check("pre_rst_count", bus.count, 3);
      #2 rst = 0;
      #1;
      check("rst_mid_count", bus.count, 0);
      check("rst_mid_ready", bus.ready, 0);
      check("rst_mid_full", bus.full, 0);
      check("rst_mid_r1", bus.data[0].r1, 0);
      @(negedge clk);
      rst = 1;
      tick();
      set_load(3'd2, 4'd9, 32'd7, 1, 4'd0, 32'd8, 1, 4'd0);
      tick(); idle();
      check("post_rst_tag0", bus.data[0].tag, 9);
      check("post_rst_ready", bus.ready, 8'h01);
      check("post_rst_count", bus.count, 1);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
